// File: rtl/edge_impulse_generator_n.sv
// Purpose : N-channel synchronised edge detector emitting fixed WIDTH-cycle pulses.
// Latency : z rises on the 3rd posedge after x changes (2-flop sync + edge register).
// Backpressure: none; edges arriving mid-pulse either restart it or set a sticky ovr flag.
//
// Ports:
//   clock     - system clock, all state updates on posedge
//   reset     - asynchronous active-high reset, clears every register
//   x         - N asynchronous level inputs, one per channel
//   mode      - edge select shared by all channels: 00 off, 01 rise, 10 fall, 11 both
//   clear_ovr - synchronous clear of all ovr bits (a same-cycle overrun wins)
//   z         - N registered pulse outputs, each high for WIDTH cycles per accepted edge
//   ovr       - N sticky overrun flags, set when an edge is dropped during a pulse
module edge_impulse_generator_n #(
  parameter int N         = 4,
  parameter int WIDTH     = 5,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] x,
  input  logic [1:0]   mode,
  input  logic         clear_ovr,
  output logic [N-1:0] z,
  output logic [N-1:0] ovr
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  // s1/s2 form the metastability synchroniser; prev holds the previous
  // synchronised level so edges are detected purely from registered values.
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] prev;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] ev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= x;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
  assign ev   = ({N{mode[0]}} & rise) | ({N{mode[1]}} & fall);

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          z_q;
    logic          ovr_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
        z_q   <= 1'b0;
        ovr_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ev[i]) begin
              state <= PULSE;
              cnt   <= CNT_LOAD;
              z_q   <= 1'b1;
            end
          end
          PULSE: begin
            if (ev[i] && RETRIGGER) begin
              // Restart in place: z stays high, no gap between pulses.
              cnt <= CNT_LOAD;
            end else if (cnt > CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              // Final pulse cycle; an edge seen here is dropped, not queued.
              state <= IDLE;
              cnt   <= '0;
              z_q   <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            z_q   <= 1'b0;
          end
        endcase

        // Setting takes priority so an overrun coincident with a clear is kept.
        if (state == PULSE && ev[i] && !RETRIGGER) begin
          ovr_q <= 1'b1;
        end else if (clear_ovr) begin
          ovr_q <= 1'b0;
        end
      end
    end

    assign z[i]   = z_q;
    assign ovr[i] = ovr_q;
  end

endmodule
